// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator and its game-tick divider.
// Defaults describe 640x480@60 driven from a 50 MHz board clock.
package vga_timing_pkg;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CW       = 10;
   localparam int DEF_TICK_DIV = 600000;

   // Registered per-pixel decode, always aligned with the hcount/vcount of the same cycle.
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
      logic line_start;
      logic frame_start;
   } vga_decode_t;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int tick_period(input int tick_div, input logic [1:0] sel);
      return tick_div >> sel;
   endfunction

endpackage

// File: rtl/vga_timing_gen_tick.sv
// Game-tick divider: one-cycle tick every TICK_DIV>>speed_sel enabled clk_in cycles.
// A new speed_sel is sampled only when a tick fires, so the running period always completes.
module vga_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       enable_i,
   input  logic [1:0] speed_sel_i,
   output logic       tick_o
);

   localparam int            TW    = $clog2(TICK_DIV + 1);
   localparam logic [TW-1:0] P_RST = TW'(TICK_DIV);

   logic [TW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] per_q, per_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      tick_d = 1'b0;
      if (enable_i) begin
         if (cnt_q == per_q - TW'(1)) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            per_d  = TW'(tick_period(TICK_DIV, speed_sel_i));
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         per_q  <= P_RST;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, sync decode and frame counter.
// Define VGA_GAME_TICK_EN to compile in the speed-selectable game-tick generator (vga_tick_gen).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV  = DEF_CLK_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CW       = DEF_CW,
   parameter int   TICK_DIV = DEF_TICK_DIV
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          enable,
   input  logic [1:0]    speed_sel,
   output logic          pix_ce,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hs,
   output logic          vs,
   output logic          active,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_cnt,
   output logic          game_tick
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic          pix_ce_q, pix_ce_d;
   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   vga_decode_t   dec_q, dec_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          div_wrap, adv, h_wrap, v_wrap;

   assign div_wrap = (div_q == DIV_LAST);
   assign adv      = enable && div_wrap;
   assign h_wrap   = (hcount_q == H_LAST);
   assign v_wrap   = (vcount_q == V_LAST);

   always_comb begin
      div_d    = div_q;
      pix_ce_d = 1'b0;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (enable) begin
         div_d = div_wrap ? '0 : div_q + DW'(1);
      end
      if (adv) begin
         pix_ce_d = 1'b1;
         hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
         if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + CW'(1);
         end
      end
   end

   // Decode from next-state counters so registered flags line up with the counters they describe.
   always_comb begin
      dec_d.hs          = (hcount_d >= HS_BEG && hcount_d < HS_END) ? HS_POL : ~HS_POL;
      dec_d.vs          = (vcount_d >= VS_BEG && vcount_d < VS_END) ? VS_POL : ~VS_POL;
      dec_d.active      = (hcount_d < H_ACT) && (vcount_d < V_ACT);
      dec_d.line_start  = adv && h_wrap;
      dec_d.frame_start = adv && h_wrap && v_wrap;
      frame_cnt_d       = frame_cnt_q + {15'd0, dec_d.frame_start};
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         div_q             <= '0;
         pix_ce_q          <= 1'b0;
         hcount_q          <= H_LAST;
         vcount_q          <= V_LAST;
         dec_q.hs          <= ~HS_POL;
         dec_q.vs          <= ~VS_POL;
         dec_q.active      <= 1'b0;
         dec_q.line_start  <= 1'b0;
         dec_q.frame_start <= 1'b0;
         frame_cnt_q       <= '0;
      end else begin
         div_q       <= div_d;
         pix_ce_q    <= pix_ce_d;
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         dec_q       <= dec_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_ce      = pix_ce_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hs          = dec_q.hs;
   assign vs          = dec_q.vs;
   assign active      = dec_q.active;
   assign line_start  = dec_q.line_start;
   assign frame_start = dec_q.frame_start;
   assign frame_cnt   = frame_cnt_q;

`ifdef VGA_GAME_TICK_EN
   vga_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable_i    (enable),
      .speed_sel_i (speed_sel),
      .tick_o      (game_tick)
   );
`else
   logic unused_speed_sel;
   assign unused_speed_sel = ^speed_sel;
   assign game_tick        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 raster (CLK_DIV=2, TICK_DIV=64); a cycle model feeds a
// scoreboard queue while directed tasks check latencies, intervals, wrap, pause and async reset.
module tb_vga_timing_gen;

   localparam int CLK_DIV  = 2;
   localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
   localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
   localparam int HT = 14, VT = 7, FT = HT * VT;
   localparam int TICK_DIV = 64;

   typedef struct packed {
      logic        pix;
      logic [9:0]  hc;
      logic [9:0]  vc;
      logic        hs;
      logic        vs;
      logic        act;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
      logic        gt;
   } obs_t;

   localparam obs_t RESET_VEC = obs_t'{1'b0, 10'd13, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [1:0]  speed_sel = 2'd0;
   logic        pix_ce, hs, vs, active, line_start, frame_start, game_tick;
   logic [9:0]  hcount, vcount;
   logic [15:0] frame_cnt;

   int          tests = 0;
   int          fails = 0;
   obs_t        exp_q[$];
   int          en_cycles = 0;
   logic [15:0] fc_off = 16'd0;
`ifdef VGA_GAME_TICK_EN
   int          next_tick = TICK_DIV;
`endif

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV), .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HS_POL (1'b0), .VS_POL (1'b0), .CW (10), .TICK_DIV (TICK_DIV)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable),
      .speed_sel   (speed_sel),
      .pix_ce      (pix_ce),
      .hcount      (hcount),
      .vcount      (vcount),
      .hs          (hs),
      .vs          (vs),
      .active      (active),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt),
      .game_tick   (game_tick)
   );

   always #5 clk_in = ~clk_in;

   function automatic obs_t cur_obs();
      return {pix_ce, hcount, vcount, hs, vs, active, line_start, frame_start, frame_cnt, game_tick};
   endfunction

   // Position is derived from the number of enabled cycles since reset.
   function automatic obs_t model_out(input int ec, input bit en, input bit gt, input logic [15:0] off);
      obs_t o;
      int   n, q, hc, vc;
      n     = ec / CLK_DIV;
      q     = (n + FT - 1) % FT;
      hc    = q % HT;
      vc    = q / HT;
      o.pix = en && (ec % CLK_DIV == 0);
      o.hc  = 10'(hc);
      o.vc  = 10'(vc);
      o.hs  = !(hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC);
      o.vs  = !(vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC);
      o.act = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      o.ls  = o.pix && (hc == 0);
      o.fs  = o.ls && (vc == 0);
      o.fc  = off + 16'((n + FT - 1) / FT);
      o.gt  = gt;
      return o;
   endfunction

   function automatic logic [15:0] frames_now();
      return 16'((en_cycles / CLK_DIV + FT - 1) / FT);
   endfunction

   bit m_en, m_gt;
   always @(posedge clk_in) begin
      if (!reset) begin
         m_en = enable;
         m_gt = 1'b0;
         if (m_en) begin
            en_cycles++;
`ifdef VGA_GAME_TICK_EN
            if (en_cycles == next_tick) begin
               m_gt = 1'b1;
               next_tick += TICK_DIV >> speed_sel;
            end
`endif
         end
         exp_q.push_back(model_out(en_cycles, m_en, m_gt, fc_off));
      end
   end

   obs_t sb_exp, sb_act;
   always @(negedge clk_in) begin
      if (!reset && exp_q.size() > 0) begin
         sb_exp = exp_q.pop_front();
         sb_act = cur_obs();
         tests++;
         if (sb_act !== sb_exp) begin
            fails++;
            $display("FAIL scoreboard t=%0t got %h expected %h", $time, sb_act, sb_exp);
         end
      end
   end

   task automatic apply_reset();
      reset     = 1'b1;
      en_cycles = 0;
      fc_off    = 16'd0;
`ifdef VGA_GAME_TICK_EN
      next_tick = TICK_DIV;
`endif
      exp_q.delete();
   endtask

   // sel: 0 pix_ce, 1 frame_start, 2 game_tick. Returns limit if the pulse never arrives.
   task automatic cycles_until(input int sel, input int limit, output int c);
      bit hit;
      c = 0;
      do begin
         @(negedge clk_in);
         c++;
         hit = (sel == 0) ? pix_ce : (sel == 1) ? frame_start : game_tick;
      end while (!hit && c < limit);
   endtask

   task automatic test_reset();
      obs_t a;
      int   c;
      apply_reset();
      enable    = 1'b1;
      speed_sel = 2'd0;
      repeat (3) @(negedge clk_in);
      a = cur_obs();
      tests++;
      if (a !== RESET_VEC) begin
         fails++;
         $display("FAIL reset_state got %h expected %h", a, RESET_VEC);
      end
      reset = 1'b0;
      cycles_until(0, 20, c);
      tests++;
      if (c !== CLK_DIV) begin
         fails++;
         $display("FAIL first_pix_latency got %0d expected %0d", c, CLK_DIV);
      end
      tests++;
      if ({hcount, vcount, active, line_start, frame_start, frame_cnt} !== {10'd0, 10'd0, 3'b111, 16'd1}) begin
         fails++;
         $display("FAIL first_pixel got h=%0d v=%0d act=%b ls=%b fs=%b fc=%0d expected 0 0 1 1 1 1",
                  hcount, vcount, active, line_start, frame_start, frame_cnt);
      end
   endtask

   task automatic test_sync();
      int c, hs_lo, vs_lo, act_n;
      cycles_until(1, 300, c);
      c = 0; hs_lo = 0; vs_lo = 0; act_n = 0;
      do begin
         @(negedge clk_in);
         c++;
         if (!hs) hs_lo++;
         if (!vs) vs_lo++;
         if (active) act_n++;
      end while (!frame_start && c < 400);
      tests++;
      if (c !== 2 * FT) begin
         fails++;
         $display("FAIL frame_period got %0d expected %0d", c, 2 * FT);
      end
      tests++;
      if (hs_lo !== 2 * H_SYNC * VT) begin
         fails++;
         $display("FAIL hs_low_cycles got %0d expected %0d", hs_lo, 2 * H_SYNC * VT);
      end
      tests++;
      if (vs_lo !== 2 * HT * V_SYNC) begin
         fails++;
         $display("FAIL vs_low_cycles got %0d expected %0d", vs_lo, 2 * HT * V_SYNC);
      end
      tests++;
      if (act_n !== 2 * H_ACTIVE * V_ACTIVE) begin
         fails++;
         $display("FAIL active_cycles got %0d expected %0d", act_n, 2 * H_ACTIVE * V_ACTIVE);
      end
   endtask

   task automatic test_frame_wrap();
      int c;
      cycles_until(1, 300, c);
      repeat (20) @(negedge clk_in);
      #1;
      force dut.frame_cnt_q = 16'hFFFF;
      fc_off = 16'hFFFF - frames_now();
      repeat (2) @(negedge clk_in);
      #1;
      release dut.frame_cnt_q;
      cycles_until(1, 300, c);
      tests++;
      if (frame_cnt !== 16'd0 || !frame_start) begin
         fails++;
         $display("FAIL frame_cnt_wrap got %h fs=%b expected 0000 fs=1", frame_cnt, frame_start);
      end
      cycles_until(1, 300, c);
      tests++;
      if (frame_cnt !== 16'd1) begin
         fails++;
         $display("FAIL frame_cnt_after_wrap got %h expected 0001", frame_cnt);
      end
   endtask

   task automatic test_game_tick();
      int c, c2;
`ifdef VGA_GAME_TICK_EN
      int exp_iv[5];
      int got_iv[5];
      exp_iv = '{64, 64, 8, 8, 64};
      cycles_until(2, 200, c);
      cycles_until(2, 200, got_iv[0]);
      repeat (20) @(negedge clk_in);
      speed_sel = 2'd3;
      cycles_until(2, 200, c2);
      got_iv[1] = c2 + 20;
      cycles_until(2, 200, got_iv[2]);
      speed_sel = 2'd0;
      cycles_until(2, 200, got_iv[3]);
      cycles_until(2, 200, got_iv[4]);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (got_iv[i] !== exp_iv[i]) begin
            fails++;
            $display("FAIL tick_interval_%0d got %0d expected %0d", i, got_iv[i], exp_iv[i]);
         end
      end
`else
      c2 = 0;
      for (c = 0; c < 200; c++) begin
         @(negedge clk_in);
         if (game_tick) c2++;
      end
      tests++;
      if (c2 !== 0) begin
         fails++;
         $display("FAIL tick_disabled got %0d ticks expected 0", c2);
      end
`endif
   endtask

   task automatic test_pause();
      int          c, pulses;
      logic [9:0]  snap_h, snap_v;
      logic [15:0] snap_f;
      cycles_until(1, 300, c);
      repeat (50) @(negedge clk_in);
      enable = 1'b0;
      snap_h = hcount; snap_v = vcount; snap_f = frame_cnt;
      pulses = 0;
      repeat (37) begin
         @(negedge clk_in);
         if (pix_ce || line_start || frame_start || game_tick) pulses++;
      end
      tests++;
      if (pulses !== 0 || {hcount, vcount, frame_cnt} !== {snap_h, snap_v, snap_f}) begin
         fails++;
         $display("FAIL pause_freeze got pulses=%0d h=%0d v=%0d fc=%0d expected 0 %0d %0d %0d",
                  pulses, hcount, vcount, frame_cnt, snap_h, snap_v, snap_f);
      end
      enable = 1'b1;
      cycles_until(1, 300, c);
      tests++;
      if (c + 50 + 37 !== 2 * FT + 37) begin
         fails++;
         $display("FAIL pause_frame_interval got %0d expected %0d", c + 50 + 37, 2 * FT + 37);
      end
   endtask

   task automatic test_async_reset();
      obs_t a;
      int   c;
      repeat (23) @(negedge clk_in);
      #2;
      apply_reset();
      #1;
      a = cur_obs();
      tests++;
      if (a !== RESET_VEC) begin
         fails++;
         $display("FAIL async_reset got %h expected %h", a, RESET_VEC);
      end
      repeat (2) @(negedge clk_in);
      reset = 1'b0;
      cycles_until(0, 20, c);
      tests++;
      if (c !== CLK_DIV || frame_cnt !== 16'd1) begin
         fails++;
         $display("FAIL restart_after_reset got lat=%0d fc=%0d expected %0d 1", c, frame_cnt, CLK_DIV);
      end
`ifdef VGA_GAME_TICK_EN
      cycles_until(2, 200, c);
      tests++;
      if (c + CLK_DIV !== TICK_DIV) begin
         fails++;
         $display("FAIL first_tick_after_reset got %0d expected %0d", c + CLK_DIV, TICK_DIV);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sync();
      test_frame_wrap();
      test_game_tick();
      test_pause();
      test_async_reset();
      repeat (40) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a built-in game-tick generator, clocked from the 50 MHz board clock. It derives the pixel clock-enable, horizontal and vertical counters, sync pulses, active-video flag, line and frame markers and a frame counter. It also produces a speed-selectable slow game tick for the display and game logic. It replaces the separate pixel-clock toggle, slow-clock divider and fixed 640x480 sync machine in the game top level.

## Interface
- CLK_DIV, 2, clk_in cycles per pixel; must be ≥1. A value of 1 holds pix_ce permanently high.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch; must be ≥1.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch; must be ≥1.
- HS_POL, 0, asserted level of hs.
- VS_POL, 0, asserted level of vs.
- CW, 10, width of hcount and vcount; must hold H_TOTAL-1 and V_TOTAL-1.
- TICK_DIV, 600000, base game-tick period in clk_in cycles; TICK_DIV>>3 must be ≥2.
- clk_in  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- enable  in  1  synchronous run/pause. Low freezes all counters and dividers.
- speed_sel  in  2  game-tick period select; period = TICK_DIV>>speed_sel.
- pix_ce  out  1  one-cycle pixel clock-enable.
- hcount  out  CW  horizontal position.
- vcount  out  CW  vertical position.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- active  out  1  visible region.
- line_start  out  1  one-cycle pulse when hcount becomes 0.
- frame_start  out  1  one-cycle pulse when (hcount,vcount) becomes (0,0).
- frame_cnt  out  16  frame counter.
- game_tick  out  1  one-cycle slow tick pulse.

## Operation
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider counts 0..CLK_DIV-1 while enable is high. pix_ce is registered and high in the cycle the divider wraps.
- On pix_ce, hcount advances. hcount wraps from H_TOTAL-1 to 0; on that wrap vcount advances and wraps from V_TOTAL-1 to 0.
- Sync decode:
  - hs=HS_POL when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs uses the same rule on vcount with the V parameters and VS_POL.
  - active = (hcount<H_ACTIVE)&&(vcount<V_ACTIVE).
- hs, vs, active, line_start and frame_start are registered, decoded from next-state counter values. They always describe the hcount/vcount present in the same cycle.
- frame_cnt increments modulo 2^16 in the frame_start cycle; 0xFFFF wraps to 0.
- Game tick:
  - The counter counts clk_in cycles while enable is high.
  - When it reaches P-1 it pulses game_tick for one cycle, resets to 0, and loads P=TICK_DIV>>speed_sel for the next period.
  - speed_sel changes mid-period take effect only at the next tick.
- enable low: all counters, the divider and the tick counter hold. pix_ce, line_start, frame_start and game_tick are forced 0. hs, vs and active hold.

## Timing
- Reset values:
  - Divider 0, pix_ce 0.
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - hs=~HS_POL, vs=~VS_POL, active 0.
  - line_start 0, frame_start 0, frame_cnt 0, game_tick 0.
  - Tick counter 0, P=TICK_DIV.
- After reset deasserts with enable high, the first pix_ce occurs CLK_DIV cycles later. In that same cycle hcount=0, vcount=0, active=1, line_start=1 and frame_start=1, and frame_cnt becomes 1.
- Latency from pix_ce to counter and decode update is 0 cycles; they are coincident.
- The first game_tick occurs TICK_DIV cycles after reset release.
- A reset mid-line or mid-tick returns every register to its reset value immediately, asynchronously.
- enable rising resumes exactly where it paused; no pulse is lost or duplicated.

## Configuration
- VGA_GAME_TICK_EN defined: the tick generator and speed_sel logic are compiled in.
- VGA_GAME_TICK_EN undefined: game_tick is tied 0, speed_sel is ignored, and no tick registers exist.

## Structure
- Package vga_timing_pkg holds:
  - The 640x480@60 default constants.
  - Functions h_total/v_total.
  - A tick_period(TICK_DIV, speed_sel) helper.
- Sub-module vga_tick_gen implements the game-tick divider and is instantiated under VGA_GAME_TICK_EN.

## Test plan
- Reset and first frame, with CLK_DIV=2, H 8/2/2/2 (H_TOTAL=14) and V 4/1/1/1 (V_TOTAL=7).
  - -> Counters read 13/6 during reset.
  - -> First pix_ce at cycle 2 after release, with hcount=0, vcount=0, frame_start=1, frame_cnt=1.
- Sync decode, same parameters.
  - -> hs low exactly for hcount 10..11.
  - -> vs low for vcount 5.
  - -> active only for hcount<8 and vcount<4.
  - -> One frame spans 14*7*2=196 clk_in cycles.
- Frame counter wrap: force frame_cnt to 0xFFFF, then run one frame -> frame_cnt=0 at the next frame_start.
- Game tick with TICK_DIV=64.
  - -> speed_sel=0 gives ticks every 64 cycles.
  - -> Switching to 3 mid-period gives the next interval still 64, then 8.
- Pause: drop enable for 37 cycles mid-line.
  - -> Counters, divider and tick counter are frozen, with no pulses.
  - -> After resume, the intervals measured excluding the pause are unchanged.
- Async reset asserted mid-tick and mid-frame -> all outputs reach reset values without a clock edge.
